// File: rtl/vscan_pkg.sv
// +--------------------------------------------------------------------------+
// | vscan_pkg                                                                |
// | Shared constants, FSM state and vector types for the image scan ctrl.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package vscan_pkg;

  localparam int IMAGE_WIDTH  = 96;
  localparam int IMAGE_HEIGHT = 96;
  localparam int IMG_PIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int LANES        = 8;
  localparam int VEC_N        = 16;
  localparam int ELEM_W       = 16;
  localparam int N_W          = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vscan_state_t;

  typedef logic [VEC_N-1:0][ELEM_W-1:0] vec_t;

  // Low n bits set; lanes at or above n are invalid.
  function automatic logic [VEC_N-1:0] lane_mask(input logic [N_W-1:0] n);
    logic [VEC_N-1:0] m;
    m = '0;
    for (int i = 0; i < VEC_N; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vscan_out_reg.sv
// +--------------------------------------------------------------------------+
// | vscan_out_reg                                                            |
// | Output register stage: loads a vector, holds it until valid&&ready.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vscan_out_reg #(
  parameter int DATA_W = 256,
  parameter int MASK_W = 16,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [MASK_W-1:0] o_mask,
  output logic [IDX_W-1:0]  o_idx
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [MASK_W-1:0] r_mask;
  logic [IDX_W-1:0]  r_idx;

  // The controller only asserts i_load when the slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_mask  <= i_mask;
      r_idx   <= i_idx;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mask  = r_mask;
  assign o_idx   = r_idx;

endmodule

`default_nettype wire

// File: rtl/vec_image_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | vec_image_scan_ctrl                                                      |
// | Walks a pixel range in LANES-wide chunks and streams masked vectors.     |
// | Optional: VSCAN_ROW_ALIGN_EN keeps every chunk inside a single row.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vec_image_scan_ctrl
  import vscan_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    start,
  input  logic [15:0]             base_addr,
  input  logic [15:0]             num_pix,
  output logic [15:0]             mem_addr,
  input  logic [VEC_N*ELEM_W-1:0] mem_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VEC_N*ELEM_W-1:0] out_data,
  output logic [VEC_N-1:0]        out_mask,
  output logic [15:0]             out_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    range_err
);

  vscan_state_t     r_state;
  vscan_state_t     w_state_nxt;

  logic [15:0]      r_cur;
  logic [15:0]      r_rem;
  logic [15:0]      r_idx;
  logic [15:0]      r_last_addr;
  logic             r_err;

  logic             w_start_ok;
  logic [15:0]      w_rem_init;
  logic [16:0]      w_end;
  logic             w_range_bad;
  logic             w_load;
  logic             w_last;
  logic [N_W-1:0]   w_n;
  logic [VEC_N-1:0] w_mask;
  vec_t             w_rd;
  vec_t             w_masked;

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_rem_init  = (num_pix == 16'd0) ? 16'(IMG_PIX) : num_pix;
  assign w_end       = {1'b0, base_addr} + {1'b0, w_rem_init};
  assign w_range_bad = (w_end > 17'(IMG_PIX));

  assign w_load = (r_state == RUN) && (!out_valid || out_ready);
  assign w_last = (r_rem == 16'(w_n));

`ifdef VSCAN_ROW_ALIGN_EN
  localparam int COL_W = $clog2(IMAGE_WIDTH + 1);

  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_cols_left;
  logic [COL_W-1:0] w_col_sum;

  assign w_cols_left = COL_W'(IMAGE_WIDTH) - r_col;
  assign w_col_sum   = r_col + COL_W'(w_n);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_col <= '0;
    end else if (w_start_ok) begin
      r_col <= COL_W'(base_addr % 16'(IMAGE_WIDTH));
    end else if (w_load) begin
      r_col <= (w_col_sum == COL_W'(IMAGE_WIDTH)) ? '0 : w_col_sum;
    end
  end
`endif

  // Chunk size: min(LANES, rem[, columns left in the row]).
  always_comb begin
    w_n = N_W'(LANES);
    if (r_rem < 16'(LANES)) begin
      w_n = r_rem[N_W-1:0];
    end
`ifdef VSCAN_ROW_ALIGN_EN
    if (16'(w_cols_left) < 16'(w_n)) begin
      w_n = w_cols_left[N_W-1:0];
    end
`endif
  end

  assign w_mask = lane_mask(w_n);
  assign w_rd   = mem_rd;

  for (genvar g = 0; g < VEC_N; g++) begin : g_lane
    assign w_masked[g] = w_mask[g] ? w_rd[g] : '0;
  end

  // In IDLE/DRAIN/DONE the port shows the address of the last captured chunk.
  assign mem_addr = (r_state == RUN) ? r_cur : r_last_addr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cur       <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_last_addr <= '0;
      r_err       <= 1'b0;
    end else if (w_start_ok) begin
      r_cur <= base_addr;
      r_rem <= w_rem_init;
      r_idx <= '0;
      r_err <= w_range_bad;
    end else if (w_load) begin
      r_cur       <= r_cur + 16'(w_n);
      r_rem       <= r_rem - 16'(w_n);
      r_idx       <= r_idx + 16'd1;
      r_last_addr <= r_cur;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    range_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_range_bad ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_load && w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        range_err   = r_err;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  vscan_out_reg #(
    .DATA_W (VEC_N*ELEM_W),
    .MASK_W (VEC_N),
    .IDX_W  (16)
  ) u_out_reg (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_load  (w_load),
    .i_ready (out_ready),
    .i_data  (w_masked),
    .i_mask  (w_mask),
    .i_idx   (r_idx),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_mask  (out_mask),
    .o_idx   (out_idx)
  );

endmodule

`default_nettype wire

// File: tb/tb_vec_image_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_vec_image_scan_ctrl                                                   |
// | Scoreboard bench: directed scans, expected vectors queued at stimulus.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vec_image_scan_ctrl;

  logic         CLK;
  logic         RST_N;
  logic         start;
  logic [15:0]  base_addr;
  logic [15:0]  num_pix;
  logic [15:0]  mem_addr;
  logic [255:0] mem_rd;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [15:0]  out_mask;
  logic [15:0]  out_idx;
  logic         busy;
  logic         done;
  logic         range_err;

  typedef struct {
    logic [255:0] data;
    logic [15:0]  mask;
    logic [15:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   last_hs;
  bit   chk_b2b;

  vec_image_scan_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .base_addr (base_addr),
    .num_pix   (num_pix),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  function automatic logic [15:0] pix(input int a);
    logic [31:0] t;
    t = (a * 7) ^ 32'h0000C3A5;
    return t[15:0];
  endfunction

  // Image memory: combinational read, 16 consecutive pixels per word.
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 16; i++) begin
      mem_rd[i*16 +: 16] = pix(int'(mem_addr) + i);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_chunk(input int p, input int n, input int idx);
    exp_t e;
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < n; i++) begin
      e.data[i*16 +: 16] = pix(p + i);
      e.mask[i]          = 1'b1;
    end
    e.idx = 16'(idx);
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    base_addr = b;
    num_pix   = n;
    start     = 1'b1;
    @(posedge CLK);
    #1 start  = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge CLK);
      if (k == 0 && !exp_err) check({tag, "_busy"}, busy, 1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done in 5000 cycles, expected done pulse", tag);
    end else begin
      check({tag, "_range_err"}, range_err, exp_err);
      check({tag, "_busy_at_done"}, busy, 0);
      if (!exp_err) check({tag, "_done_latency"}, cyc, last_hs + 1);
      @(negedge CLK);
      check({tag, "_done_1cyc"}, done, 0);
      check({tag, "_sb_empty"}, sb.size(), 0);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops on every handshake and checks hold behaviour during stalls.
  initial begin
    exp_t         e;
    bit           prev_stall;
    logic [255:0] prev_data;
    logic [15:0]  prev_mask;
    logic [15:0]  prev_idx;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_mask  = '0;
    prev_idx   = '0;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_mask", out_mask, prev_mask);
          check("hold_idx", out_idx, prev_idx);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_vector: got idx %0d, expected no vector", out_idx);
          end else begin
            e = sb.pop_front();
            check("vec_data", out_data, e.data);
            check("vec_mask", out_mask, e.mask);
            check("vec_idx", out_idx, e.idx);
            if (chk_b2b && out_idx != 16'd0) check("b2b_cycle", cyc, last_hs + 1);
          end
          last_hs = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_mask  = out_mask;
        prev_idx   = out_idx;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    bit got_v;
    n_tests   = 0;
    n_fail    = 0;
    last_hs   = 0;
    chk_b2b   = 1'b1;
    RST_N     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_pix   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_range_err", range_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_out_idx", out_idx, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Two full chunks back to back.
    push_chunk(0, 8, 0);
    push_chunk(8, 8, 1);
    do_start(16'd0, 16'd16);
    wait_done(1'b0, "t1");

    // Partial final chunk.
    push_chunk(100, 8, 0);
    push_chunk(108, 5, 1);
    do_start(16'd100, 16'd13);
    wait_done(1'b0, "t2");

    // Three stalled cycles on the first vector, plus a start pulse while busy.
    chk_b2b   = 1'b0;
    out_ready = 1'b0;
    push_chunk(200, 8, 0);
    push_chunk(208, 8, 1);
    do_start(16'd200, 16'd16);
    got_v = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (out_valid) begin
        got_v = 1'b1;
        break;
      end
    end
    check("t3_valid_seen", got_v, 1);
    @(posedge CLK);
    #1;
    base_addr = 16'd500;
    num_pix   = 16'd8;
    start     = 1'b1;
    @(posedge CLK);
    #1 start  = 1'b0;
    @(posedge CLK);
    #1 out_ready = 1'b1;
    wait_done(1'b0, "t3");
    chk_b2b = 1'b1;

    // Range overflow: no vectors, error with done.
    do_start(16'd9210, 16'd10);
    wait_done(1'b1, "t4");

    // Whole image.
    for (int k = 0; k < 1152; k++) push_chunk(k * 8, 8, k);
    do_start(16'd0, 16'd0);
    wait_done(1'b0, "t5");

    // Reset while a vector is pending.
    out_ready = 1'b0;
    do_start(16'd0, 16'd64);
    got_v = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (out_valid) begin
        got_v = 1'b1;
        break;
      end
    end
    check("t6_valid_seen", got_v, 1);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    RST_N     = 1'b1;
    out_ready = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (done || out_valid) seen_done = 1'b1;
    end
    check("t6_no_done_after_rst", seen_done, 0);
    @(posedge CLK);
    #1;
    push_chunk(40, 8, 0);
    push_chunk(48, 8, 1);
    do_start(16'd40, 16'd16);
    wait_done(1'b0, "t6_restart");

    // Row-boundary case.
`ifdef VSCAN_ROW_ALIGN_EN
    push_chunk(92, 4, 0);
    push_chunk(96, 4, 1);
`else
    push_chunk(92, 8, 0);
`endif
    do_start(16'd92, 16'd8);
    wait_done(1'b0, "t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
